// File: rtl/mem_word_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_sequencer_pkg
// Description : Shared state encodings, beat count, port IDs and byte-lane
//               helper for the byte-serialising word sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_word_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    localparam int unsigned c_beats    = 4;
    localparam logic        c_p_ifetch = 1'b0;
    localparam logic        c_p_data   = 1'b1;

    // Big-endian lane select: index 0 is the most significant byte.
    function automatic logic [7:0] f_word_byte(input logic [31:0] word,
                                               input logic [1:0]  idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_word_sequencer_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter; owns the last-grant register.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
    import mem_word_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    logic r_last_grant_q;
    logic w_last_grant_d;

    always_comb begin
        grant          = 2'b00;
        w_last_grant_d = r_last_grant_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (r_last_grant_q == c_p_data) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (update) begin
            w_last_grant_d = grant[1];
        end
    end

    // Reset to the data port so the fetch port wins the first contention.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_grant_q <= c_p_data;
        end else begin
            r_last_grant_q <= w_last_grant_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_word_sequencer
// Description : Shares one byte-wide RAM port between an instruction-fetch
//               port and a data port, serialising each word into 4 beats.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_word_sequencer
    import mem_word_sequencer_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              ack0,
    output logic [31:0]       rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    output logic              ack1,
    output logic [31:0]       rdata1,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata
);

    state_e              r_state_q,  w_state_d;
    logic [1:0]          r_beat_q,   w_beat_d;
    logic                r_port_q,   w_port_d;
    logic                r_we_q,     w_we_d;
    logic [ADDR_W-1:0]   r_base_q,   w_base_d;
    logic [31:0]         r_wdata_q,  w_wdata_d;
    logic [23:0]         r_word_q,   w_word_d;
    logic [31:0]         r_rdata0_q, w_rdata0_d;
    logic [31:0]         r_rdata1_q, w_rdata1_d;
    logic                r_ack0_q,   w_ack0_d;
    logic                r_ack1_q,   w_ack1_d;

    logic [1:0]          w_grant;
    logic                w_update;
    logic                w_in_xfer;

    assign w_update = (r_state_q == ST_IDLE) && (w_grant != 2'b00);

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1, req0}),
        .update (w_update),
        .grant  (w_grant)
    );

    always_comb begin
        w_state_d  = r_state_q;
        w_beat_d   = r_beat_q;
        w_port_d   = r_port_q;
        w_we_d     = r_we_q;
        w_base_d   = r_base_q;
        w_wdata_d  = r_wdata_q;
        w_word_d   = r_word_q;
        w_rdata0_d = r_rdata0_q;
        w_rdata1_d = r_rdata1_q;
        w_ack0_d   = 1'b0;
        w_ack1_d   = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_grant != 2'b00) begin
                    w_port_d  = w_grant[1] ? c_p_data : c_p_ifetch;
                    w_base_d  = w_grant[1] ? addr1 : addr0;
                    w_we_d    = w_grant[1] & we1;
                    w_wdata_d = w_grant[1] ? wdata1 : 32'h0;
                    w_beat_d  = 2'd0;
                    w_state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                // Read data trails the address by one beat, so beat k lands byte k-1.
                case (r_beat_q)
                    2'd1:    w_word_d[23:16] = ram_rdata;
                    2'd2:    w_word_d[15:8]  = ram_rdata;
                    2'd3:    w_word_d[7:0]   = ram_rdata;
                    default: w_word_d        = r_word_q;
                endcase
                w_beat_d = r_beat_q + 2'd1;
                if (r_beat_q == 2'(c_beats - 1)) begin
                    w_state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_we_q) begin
                    if (r_port_q == c_p_data) begin
                        w_rdata1_d = {r_word_q, ram_rdata};
                    end else begin
                        w_rdata0_d = {r_word_q, ram_rdata};
                    end
                end
                w_ack0_d  = (r_port_q == c_p_ifetch);
                w_ack1_d  = (r_port_q == c_p_data);
                w_state_d = ST_ACK;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q  <= ST_IDLE;
            r_beat_q   <= 2'd0;
            r_port_q   <= 1'b0;
            r_we_q     <= 1'b0;
            r_base_q   <= '0;
            r_wdata_q  <= 32'h0;
            r_word_q   <= 24'h0;
            r_rdata0_q <= 32'h0;
            r_rdata1_q <= 32'h0;
            r_ack0_q   <= 1'b0;
            r_ack1_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_beat_q   <= w_beat_d;
            r_port_q   <= w_port_d;
            r_we_q     <= w_we_d;
            r_base_q   <= w_base_d;
            r_wdata_q  <= w_wdata_d;
            r_word_q   <= w_word_d;
            r_rdata0_q <= w_rdata0_d;
            r_rdata1_q <= w_rdata1_d;
            r_ack0_q   <= w_ack0_d;
            r_ack1_q   <= w_ack1_d;
        end
    end

    assign w_in_xfer = (r_state_q == ST_XFER);
    assign ram_addr  = w_in_xfer ? (r_base_q + {{(ADDR_W-2){1'b0}}, r_beat_q}) : '0;
    assign ram_we    = w_in_xfer & r_we_q;
    assign ram_wdata = w_in_xfer ? f_word_byte(r_wdata_q, r_beat_q) : 8'h00;

    assign ack0   = r_ack0_q;
    assign ack1   = r_ack1_q;
    assign rdata0 = r_rdata0_q;
    assign rdata1 = r_rdata1_q;
    assign busy   = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_word_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_word_sequencer
// Description : Directed self-checking bench with a 64 KiB byte RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_word_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, req0, req1, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] wdata1;
    logic        ack0, ack1, busy, ram_we;
    logic [31:0] rdata0, rdata1;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;

    logic [7:0]  mem [0:65535];
    logic        pl_en;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_word_sequencer #(.ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1), .busy(busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic preload_word(input logic [15:0] a, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            pl_en   = 1'b1;
            pl_addr = a + 16'(i);
            pl_data = w[31-8*i -: 8];
            @(posedge clk); #1;
        end
        pl_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total += 8;
        if (ack0 !== 1'b0)       begin bad++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
        if (ack1 !== 1'b0)       begin bad++; $display("FAIL reset_ack1 got=%b exp=0", ack1); end
        if (busy !== 1'b0)       begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (ram_we !== 1'b0)     begin bad++; $display("FAIL reset_ram_we got=%b exp=0", ram_we); end
        if (ram_addr !== 16'h0)  begin bad++; $display("FAIL reset_ram_addr got=%h exp=0000", ram_addr); end
        if (ram_wdata !== 8'h0)  begin bad++; $display("FAIL reset_ram_wdata got=%h exp=00", ram_wdata); end
        if (rdata0 !== 32'h0)    begin bad++; $display("FAIL reset_rdata0 got=%h exp=0", rdata0); end
        if (rdata1 !== 32'h0)    begin bad++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
    endtask

    // Both ports request continuously straight out of reset.
    task automatic test_arbitration();
        logic [28:0] v_ack0, v_ack1, v_busy;
        logic        any_we;
        logic [31:0] r0_at6, r1_at13;
        v_ack0 = '0; v_ack1 = '0; v_busy = '0; any_we = 1'b0;
        r0_at6 = '0; r1_at13 = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        req0 = 1'b1; addr0 = 16'h0030;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020;
        for (int c = 0; c <= 28; c++) begin
            @(negedge clk);
            v_ack0[c] = ack0; v_ack1[c] = ack1; v_busy[c] = busy;
            any_we |= ram_we;
            if (c == 6)  r0_at6  = rdata0;
            if (c == 13) r1_at13 = rdata1;
            @(posedge clk); #1;
            if (c == 27) begin req0 = 1'b0; req1 = 1'b0; end
        end
        total += 6;
        if (v_ack0 !== 29'h0010_0040) begin bad++; $display("FAIL arb_ack0_cycles got=%h exp=%h", v_ack0, 29'h0010_0040); end
        if (v_ack1 !== 29'h0800_2000) begin bad++; $display("FAIL arb_ack1_cycles got=%h exp=%h", v_ack1, 29'h0800_2000); end
        if (v_busy !== 29'h0FDF_BF7E) begin bad++; $display("FAIL arb_busy got=%h exp=%h", v_busy, 29'h0FDF_BF7E); end
        if (any_we !== 1'b0)          begin bad++; $display("FAIL arb_ram_we got=%b exp=0", any_we); end
        if (r0_at6 !== 32'hCAFEF00D)  begin bad++; $display("FAIL arb_rdata0 got=%h exp=cafef00d", r0_at6); end
        if (r1_at13 !== 32'h01020304) begin bad++; $display("FAIL arb_rdata1 got=%h exp=01020304", r1_at13); end
    endtask

    task automatic test_read();
        logic [15:0] a [0:7];
        logic [7:0]  v_ack0;
        logic        any_we;
        logic [31:0] r_c5, r_c6;
        v_ack0 = '0; any_we = 1'b0; r_c5 = '0; r_c6 = '0;
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = 16'h0010;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            a[c] = ram_addr; v_ack0[c] = ack0; any_we |= ram_we;
            if (c == 5) r_c5 = rdata0;
            if (c == 6) r_c6 = rdata0;
            @(posedge clk); #1;
            if (c == 6) req0 = 1'b0;
        end
        total += 8;
        if (a[0] !== 16'h0000) begin bad++; $display("FAIL read_addr_c0 got=%h exp=0000", a[0]); end
        if (a[1] !== 16'h0010) begin bad++; $display("FAIL read_addr_c1 got=%h exp=0010", a[1]); end
        if (a[4] !== 16'h0013) begin bad++; $display("FAIL read_addr_c4 got=%h exp=0013", a[4]); end
        if (a[5] !== 16'h0000) begin bad++; $display("FAIL read_addr_c5 got=%h exp=0000", a[5]); end
        if (v_ack0 !== 8'h40)  begin bad++; $display("FAIL read_ack0_cycles got=%h exp=40", v_ack0); end
        if (any_we !== 1'b0)   begin bad++; $display("FAIL read_ram_we got=%b exp=0", any_we); end
        if (r_c5 !== 32'hCAFEF00D) begin bad++; $display("FAIL read_rdata0_hold got=%h exp=cafef00d", r_c5); end
        if (r_c6 !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata0 got=%h exp=deadbeef", r_c6); end
    endtask

    task automatic test_write();
        logic [7:0]  v_we, v_ack1, v_ack1b;
        logic [31:0] r1_wr, r1_rd;
        v_we = '0; v_ack1 = '0; v_ack1b = '0; r1_wr = '0; r1_rd = '0;
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0100; wdata1 = 32'h11223344;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            v_we[c] = ram_we; v_ack1[c] = ack1;
            if (c == 6) r1_wr = rdata1;
            @(posedge clk); #1;
            if (c == 6) req1 = 1'b0;
        end
        req1 = 1'b1; we1 = 1'b0; wdata1 = 32'h0;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            v_ack1b[c] = ack1;
            if (c == 6) r1_rd = rdata1;
            @(posedge clk); #1;
            if (c == 6) req1 = 1'b0;
        end
        total += 9;
        if (v_we !== 8'h1E)   begin bad++; $display("FAIL write_ram_we_cycles got=%h exp=1e", v_we); end
        if (v_ack1 !== 8'h40) begin bad++; $display("FAIL write_ack1_cycles got=%h exp=40", v_ack1); end
        if (mem[16'h0100] !== 8'h11) begin bad++; $display("FAIL write_byte0 got=%h exp=11", mem[16'h0100]); end
        if (mem[16'h0101] !== 8'h22) begin bad++; $display("FAIL write_byte1 got=%h exp=22", mem[16'h0101]); end
        if (mem[16'h0102] !== 8'h33) begin bad++; $display("FAIL write_byte2 got=%h exp=33", mem[16'h0102]); end
        if (mem[16'h0103] !== 8'h44) begin bad++; $display("FAIL write_byte3 got=%h exp=44", mem[16'h0103]); end
        if (r1_wr !== 32'h01020304)  begin bad++; $display("FAIL write_rdata1_untouched got=%h exp=01020304", r1_wr); end
        if (v_ack1b !== 8'h40)       begin bad++; $display("FAIL readback_ack1_cycles got=%h exp=40", v_ack1b); end
        if (r1_rd !== 32'h11223344)  begin bad++; $display("FAIL readback_rdata1 got=%h exp=11223344", r1_rd); end
    endtask

    task automatic test_wrap();
        logic [15:0] a [0:7];
        logic [31:0] r_c6;
        r_c6 = '0;
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = 16'hFFFE;
        for (int c = 0; c <= 7; c++) begin
            @(negedge clk);
            a[c] = ram_addr;
            if (c == 6) r_c6 = rdata0;
            @(posedge clk); #1;
            if (c == 6) req0 = 1'b0;
        end
        total += 5;
        if (a[1] !== 16'hFFFE) begin bad++; $display("FAIL wrap_addr_c1 got=%h exp=fffe", a[1]); end
        if (a[2] !== 16'hFFFF) begin bad++; $display("FAIL wrap_addr_c2 got=%h exp=ffff", a[2]); end
        if (a[3] !== 16'h0000) begin bad++; $display("FAIL wrap_addr_c3 got=%h exp=0000", a[3]); end
        if (a[4] !== 16'h0001) begin bad++; $display("FAIL wrap_addr_c4 got=%h exp=0001", a[4]); end
        if (r_c6 !== 32'hA1B2C3D4) begin bad++; $display("FAIL wrap_rdata0 got=%h exp=a1b2c3d4", r_c6); end
    endtask

    task automatic test_reset_mid_write();
        logic [8:0]  v_ack1, v_busy, v_we;
        logic [31:0] r0_c3, r1_c3;
        v_ack1 = '0; v_busy = '0; v_we = '0; r0_c3 = '0; r1_c3 = '0;
        @(posedge clk); #1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0200; wdata1 = 32'hAABBCCDD;
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            v_ack1[c] = ack1; v_busy[c] = busy; v_we[c] = ram_we;
            if (c == 3) begin r0_c3 = rdata0; r1_c3 = rdata1; end
            @(posedge clk); #1;
            if (c == 1) begin rst_n = 1'b0; req1 = 1'b0; we1 = 1'b0; end
            if (c == 2) rst_n = 1'b1;
        end
        total += 9;
        if (mem[16'h0200] !== 8'hAA) begin bad++; $display("FAIL rstmid_byte0 got=%h exp=aa", mem[16'h0200]); end
        if (mem[16'h0201] !== 8'hBB) begin bad++; $display("FAIL rstmid_byte1 got=%h exp=bb", mem[16'h0201]); end
        if (mem[16'h0202] !== 8'h66) begin bad++; $display("FAIL rstmid_byte2 got=%h exp=66", mem[16'h0202]); end
        if (mem[16'h0203] !== 8'h77) begin bad++; $display("FAIL rstmid_byte3 got=%h exp=77", mem[16'h0203]); end
        if (v_ack1 !== 9'h000)         begin bad++; $display("FAIL rstmid_ack1 got=%h exp=000", v_ack1); end
        if (v_busy[8:3] !== 6'h00)     begin bad++; $display("FAIL rstmid_busy got=%h exp=00", v_busy[8:3]); end
        if (v_we !== 9'h006)           begin bad++; $display("FAIL rstmid_ram_we got=%h exp=006", v_we); end
        if (r0_c3 !== 32'h0)           begin bad++; $display("FAIL rstmid_rdata0 got=%h exp=0", r0_c3); end
        if (r1_c3 !== 32'h0)           begin bad++; $display("FAIL rstmid_rdata1 got=%h exp=0", r1_c3); end
    endtask

    task automatic test_late_request();
        logic [15:0] v_ack0, v_ack1;
        logic [15:0] a8;
        logic [31:0] r0_c6, r0_c13, r1_c13;
        v_ack0 = '0; v_ack1 = '0; a8 = '0; r0_c6 = '0; r0_c13 = '0; r1_c13 = '0;
        @(posedge clk); #1;
        req0 = 1'b1; addr0 = 16'h0010;
        for (int c = 0; c <= 15; c++) begin
            @(negedge clk);
            v_ack0[c] = ack0; v_ack1[c] = ack1;
            if (c == 8)  a8 = ram_addr;
            if (c == 6)  r0_c6 = rdata0;
            if (c == 13) begin r0_c13 = rdata0; r1_c13 = rdata1; end
            @(posedge clk); #1;
            if (c == 2)  begin req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0020; end
            if (c == 6)  req0 = 1'b0;
            if (c == 13) req1 = 1'b0;
        end
        total += 6;
        if (v_ack0 !== 16'h0040)     begin bad++; $display("FAIL late_ack0_cycles got=%h exp=0040", v_ack0); end
        if (v_ack1 !== 16'h2000)     begin bad++; $display("FAIL late_ack1_cycles got=%h exp=2000", v_ack1); end
        if (a8 !== 16'h0020)         begin bad++; $display("FAIL late_grant_addr got=%h exp=0020", a8); end
        if (r0_c6 !== 32'hDEADBEEF)  begin bad++; $display("FAIL late_rdata0 got=%h exp=deadbeef", r0_c6); end
        if (r0_c13 !== 32'hDEADBEEF) begin bad++; $display("FAIL late_rdata0_hold got=%h exp=deadbeef", r0_c13); end
        if (r1_c13 !== 32'h01020304) begin bad++; $display("FAIL late_rdata1 got=%h exp=01020304", r1_c13); end
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata1 = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        preload_word(16'h0010, 32'hDEADBEEF);
        preload_word(16'h0020, 32'h01020304);
        preload_word(16'h0030, 32'hCAFEF00D);
        preload_word(16'hFFFE, 32'hA1B2C3D4);
        preload_word(16'h0200, 32'h00006677);
        test_reset();
        test_arbitration();
        test_read();
        test_write();
        test_wrap();
        test_reset_mid_write();
        test_late_request();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
